// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and constants for the instruction-memory boot loader
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, CHECKSUM, DONE, ERROR} state_t;
    localparam logic [31:0] LOAD_TERMINATOR = 32'hFFFF_FFFF;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// byte_packer: shifts accepted bytes big-endian into a 32-bit word and flags the 4th byte
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);
    logic [1:0] idx;

    assign word_complete = accept && idx == 2'(BYTES_PER_WORD - 1);

    // shift register and byte index; index wraps so the next word starts clean
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (accept) begin
            word <= {word[23:0], byte_in};
            idx  <= idx + 2'd1;
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: packs a byte stream into words, writes them to instruction memory, then releases the core
// Optional trailing checksum word is enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [7:0]            Byte_In,
    input  logic                  Byte_Valid,
    output logic                  Byte_Ready,
    output logic                  Imem_Write,
    output logic [ADDR_WIDTH-1:0] Imem_Addr,
    output logic [31:0]           Imem_Data,
    output logic [ADDR_WIDTH:0]   Word_Count,
    output logic                  Cpu_Run,
    output logic                  Load_Error
);
    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH + 1)'(MAX_WORDS);

    state_t state, state_nx, term_state;
    logic [31:0] word;
    logic word_complete, accept, clear, is_term, full, sum_ready, sum_match;

    assign accept  = Byte_Valid && Byte_Ready;
    assign clear   = Start && (state == IDLE || state == DONE || state == ERROR);
    assign is_term = word == LOAD_TERMINATOR;
    assign full    = Word_Count == MAX_CNT;

    byte_packer u_packer (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .accept        (accept),
        .clear         (clear),
        .byte_in       (Byte_In),
        .word          (word),
        .word_complete (word_complete)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] xor_acc;

    // running XOR of written words; sum_ready marks the compare cycle after the checksum word lands
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            xor_acc   <= '0;
            sum_ready <= 1'b0;
        end else begin
            xor_acc   <= clear ? '0 : Imem_Write ? xor_acc ^ word : xor_acc;
            sum_ready <= state == CHECKSUM && word_complete;
        end
    end

    assign sum_match  = word == xor_acc;
    assign term_state = CHECKSUM;
`else
    assign sum_ready  = 1'b0;
    assign sum_match  = 1'b0;
    assign term_state = DONE;
`endif

    // state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // words written in the current load; restarts on every accepted Start
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)        Word_Count <= '0;
        else if (clear)      Word_Count <= '0;
        else if (Imem_Write) Word_Count <= Word_Count + 1'b1;
    end

    // next-state: Start only matters outside an active load
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (Start) state_nx = ASSEMBLE;
            ASSEMBLE:    if (word_complete) state_nx = WRITE;
            WRITE:       state_nx = is_term ? term_state : full ? ERROR : ASSEMBLE;
            CHECKSUM:    if (sum_ready) state_nx = sum_match ? DONE : ERROR;
            DONE, ERROR: if (Start) state_nx = ASSEMBLE;
            default:     state_nx = IDLE;
        endcase
    end

    // outputs decoded from registered state only, so the write port never sees Byte_In directly
    always_comb begin
        Byte_Ready = state == ASSEMBLE || (state == CHECKSUM && !sum_ready);
        Imem_Write = state == WRITE && !is_term && !full;
        Imem_Addr  = Imem_Write ? Word_Count[ADDR_WIDTH-1:0] : '0;
        Imem_Data  = Imem_Write ? word : '0;
        Cpu_Run    = state == DONE;
        Load_Error = state == ERROR;
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and randomized loads checked against a word-level model of the loader
module tb_imem_boot_loader;
    localparam int AW = 10;
    localparam int MW = 4;
    localparam logic [31:0] TERM = 32'hFFFF_FFFF;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic [7:0]    Byte_In = '0;
    logic          Byte_Valid = 1'b0;
    logic          Byte_Ready, Imem_Write, Cpu_Run, Load_Error;
    logic [AW-1:0] Imem_Addr;
    logic [31:0]   Imem_Data;
    logic [AW:0]   Word_Count;

    int evals = 0;
    int fails = 0;
    int gap_lo = 0;
    int gap_hi = 0;
    bit noise = 1'b0;
    logic [31:0]      prog[$];
    logic [AW+31:0]   got[$];

    imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Byte_In    (Byte_In),
        .Byte_Valid (Byte_Valid),
        .Byte_Ready (Byte_Ready),
        .Imem_Write (Imem_Write),
        .Imem_Addr  (Imem_Addr),
        .Imem_Data  (Imem_Data),
        .Word_Count (Word_Count),
        .Cpu_Run    (Cpu_Run),
        .Load_Error (Load_Error)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (Reset_n && Imem_Write === 1'b1) begin
            got.push_back({Imem_Addr, Imem_Data});
            check("ready_in_write", 64'(Byte_Ready), 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit quiet);
        int g = $urandom_range(gap_hi, gap_lo);
        int n = 0;
        repeat (g) begin
            Byte_Valid = 1'b0;
            Start = noise && !quiet && ($urandom_range(0, 2) == 0);
            @(negedge Clock);
        end
        Start = 1'b0;
        Byte_In = b;
        Byte_Valid = 1'b1;
        while (Byte_Ready !== 1'b1 && n < 40) begin
            @(negedge Clock);
            n++;
        end
        if (n == 40) check("ready_timeout", 64'(Byte_Ready), 64'd1);
        @(negedge Clock);
        Byte_Valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit quiet);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], quiet);
    endtask

    task automatic start_load();
        got.delete();
        @(negedge Clock);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("start_run", 64'(Cpu_Run), 64'd0);
        check("start_err", 64'(Load_Error), 64'd0);
        check("start_count", 64'(Word_Count), 64'd0);
        check("start_ready", 64'(Byte_Ready), 64'd1);
    endtask

    task automatic do_load(input bit bad_cks);
        int n = prog.size();
        int exp_w = n > MW ? MW : n;
        bit ovf = n > MW;
        bit exp_err = ovf || (CKS && bad_cks);
        logic [31:0] x = '0;
        int k = 0;
        for (int i = 0; i < exp_w; i++) x ^= prog[i];
        start_load();
        for (int i = 0; i < (ovf ? MW + 1 : n); i++) send_word(prog[i], 1'b0);
        if (!ovf) begin
            send_word(TERM, 1'b0);
            if (CKS) send_word(x ^ {31'b0, bad_cks}, 1'b1);
        end
        while (!(Cpu_Run === 1'b1 || Load_Error === 1'b1) && k < 20) begin
            @(negedge Clock);
            k++;
        end
        check("end_run", 64'(Cpu_Run), 64'(!exp_err));
        check("end_err", 64'(Load_Error), 64'(exp_err));
        check("end_count", 64'(Word_Count), 64'(exp_w));
        check("write_count", 64'(got.size()), 64'(exp_w));
        for (int i = 0; i < exp_w && i < got.size(); i++)
            check("write", 64'(got[i]), 64'({AW'(i), prog[i]}));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        return w == TERM ? 32'h0 : w;
    endfunction

    initial begin
        #1;
        check("rst_ready", 64'(Byte_Ready), 64'd0);
        check("rst_write", 64'(Imem_Write), 64'd0);
        check("rst_run", 64'(Cpu_Run), 64'd0);
        check("rst_err", 64'(Load_Error), 64'd0);
        check("rst_count", 64'(Word_Count), 64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);
        check("idle_ready", 64'(Byte_Ready), 64'd0);

        prog = '{32'h2008_0005, 32'h0109_5020};
        do_load(1'b0);

        prog.delete();
        do_load(1'b0);

        prog = '{32'h1, 32'h2, 32'h3, 32'h4};
        do_load(1'b0);

        prog = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
        do_load(1'b0);

        gap_lo = 1;
        gap_hi = 1;
        noise = 1'b1;
        prog = '{32'h2008_0005, 32'h0109_5020};
        do_load(1'b0);

        if (CKS) begin
            gap_lo = 0;
            gap_hi = 0;
            prog = '{32'h1111_1111, 32'h2222_2222};
            do_load(1'b0);
            do_load(1'b1);
        end

        prog = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
        start_load();
        send_word(prog[0], 1'b0);
        send_word(prog[1], 1'b0);
        send_byte(8'hA5, 1'b0);
        check("pre_reset_writes", 64'(got.size()), 64'd2);
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(Byte_Ready), 64'd0);
        check("mid_rst_write", 64'(Imem_Write), 64'd0);
        check("mid_rst_addr", 64'(Imem_Addr), 64'd0);
        check("mid_rst_data", 64'(Imem_Data), 64'd0);
        check("mid_rst_run", 64'(Cpu_Run), 64'd0);
        check("mid_rst_err", 64'(Load_Error), 64'd0);
        check("mid_rst_count", 64'(Word_Count), 64'd0);
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        Byte_Valid = 1'b1;
        Byte_In = 8'h5A;
        repeat (3) begin
            @(negedge Clock);
            check("post_rst_ready", 64'(Byte_Ready), 64'd0);
            check("post_rst_count", 64'(Word_Count), 64'd0);
        end
        Byte_Valid = 1'b0;

        gap_lo = 0;
        gap_hi = 3;
        noise = 1'b1;
        for (int t = 0; t < 25; t++) begin
            int len = $urandom_range(0, MW + 1);
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(rand_word());
            do_load(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
